// File: rtl/me_pkg.sv
// Shared types and constants for the motion-estimation frame scheduler.
// Holds the scheduler state encoding, FIFO tags and stream widths.
package me_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_SWAP,
    S_ERR
  } sched_state_t;

  localparam logic [1:0] TAG_VEC = 2'b01;
  localparam logic [1:0] TAG_IMG = 2'b10;

  localparam int ME_MSBI = 13;
  localparam int VEC_W   = 2 * ME_MSBI + 4;
  localparam int IMG_W   = 26;
  localparam int FIFO_W  = 32;

endpackage

// File: rtl/me_fifo_arb.sv
// Combinational vector/image arbiter onto the single HPS write FIFO.
// Ports: vec/img req+data in, fifo_full in; waits, fifo_wr, fifo_data out.
module me_fifo_arb
  import me_pkg::*;
#(
  parameter int VW = VEC_W
) (
  input  logic              vec_req,
  input  logic [VW-1:0]     vec_data,
  input  logic              img_req,
  input  logic [IMG_W-1:0]  img_data,
  input  logic              fifo_full,
  output logic              vec_wait,
  output logic              img_wait,
  output logic              fifo_wr,
  output logic [FIFO_W-1:0] fifo_data
);

  logic [FIFO_W-3:0] vec_pad;
  logic [FIFO_W-3:0] img_pad;

  assign vec_pad = (FIFO_W-2)'(vec_data);
  assign img_pad = (FIFO_W-2)'(img_data);

  // Vector stream always wins; image waits whenever a vector is pending.
  always_comb begin
    vec_wait  = fifo_full;
    img_wait  = fifo_full | vec_req;
    fifo_wr   = (vec_req | img_req) & ~fifo_full;
    fifo_data = '0;
    if (vec_req) begin
      fifo_data = {TAG_VEC, vec_pad};
    end else if (img_req) begin
      fifo_data = {TAG_IMG, img_pad};
    end
  end

endmodule

// File: rtl/me_frame_sched.sv
// Frame controller: accepts frames, starts the engine under a watchdog,
// swaps bank/tag on finish and muxes engine streams onto the FIFO.
module me_frame_sched
  import me_pkg::*;
#(
  parameter int MSBI = 13,
  parameter int TO_W = 20
) (
  input  logic              clk_fsm,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              frame_valid,
  output logic              frame_ack,
  input  logic [MSBI:0]     window_cfg,
  output logic [MSBI:0]     window_limit,
  output logic              eng_start,
  input  logic              eng_finish,
  output logic [1:0]        cont_img,
  output logic              bank_sel,
  input  logic              vec_req,
  input  logic              img_req,
  input  logic [2*MSBI+3:0] vec_data,
  input  logic [IMG_W-1:0]  img_data,
  output logic              vec_wait,
  output logic              img_wait,
  input  logic              fifo_full,
  output logic              fifo_wr,
  output logic [31:0]       fifo_data,
  input  logic              abort,
  input  logic              err_clr,
  output logic              error,
  output logic [15:0]       frames_done
);

  sched_state_t state_q, state_d;
  logic [MSBI:0] win_q, win_d;
  logic [1:0]    tag_q, tag_d;
  logic          bank_q, bank_d;
  logic [15:0]   done_q, done_d;
  logic [TO_W-1:0] wd_q, wd_d, wd_inc;
  logic          stall;

  // Engine is held off the FIFO: watchdog time does not count.
  assign stall  = (vec_req | img_req) & fifo_full;
  assign wd_inc = wd_q + {{(TO_W-1){1'b0}}, ~stall};

  always_ff @(posedge clk_fsm or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      tag_q   <= '0;
      bank_q  <= 1'b0;
      done_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      tag_q   <= tag_d;
      bank_q  <= bank_d;
      done_q  <= done_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    tag_d     = tag_q;
    bank_d    = bank_q;
    done_d    = done_q;
    wd_d      = wd_q;
    frame_ack = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable && frame_valid) begin
          frame_ack = 1'b1;
          // A zero window is acknowledged and dropped.
          if (window_cfg != '0) begin
            win_d   = window_cfg;
            state_d = S_START;
          end
        end
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (eng_finish) begin
          state_d = S_SWAP;
        end else begin
          wd_d = wd_inc;
          if (abort || (&wd_inc)) begin
            state_d = S_ERR;
          end
        end
      end
      S_SWAP: begin
        bank_d  = ~bank_q;
        tag_d   = tag_q + 2'd1;
        if (done_q != 16'hFFFF) begin
          done_d = done_q + 16'd1;
        end
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (err_clr) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign eng_start    = (state_q == S_START);
  assign error        = (state_q == S_ERR);
  assign window_limit = win_q;
  assign cont_img     = tag_q;
  assign bank_sel     = bank_q;
  assign frames_done  = done_q;

  me_fifo_arb #(
    .VW(2*MSBI+4)
  ) u_arb (
    .vec_req  (vec_req),
    .vec_data (vec_data),
    .img_req  (img_req),
    .img_data (img_data),
    .fifo_full(fifo_full),
    .vec_wait (vec_wait),
    .img_wait (img_wait),
    .fifo_wr  (fifo_wr),
    .fifo_data(fifo_data)
  );

endmodule

// File: tb/tb_me_frame_sched.sv
// Scoreboard bench for me_frame_sched: frame-level model pushes
// expected events, a negedge monitor pops and compares them.
module tb_me_frame_sched;

  localparam int MSBI = 13;
  localparam int TO_W = 4;

  typedef struct {
    int         cyc;
    logic [13:0] win;
    logic       start;
  } ack_t;

  typedef struct {
    int          cyc;
    logic        err;
    logic [1:0]  tag;
    logic        bank;
    logic [15:0] done;
  } st_t;

  typedef struct {
    logic        wr;
    logic        vw;
    logic        iw;
    logic [31:0] data;
  } arb_t;

  logic clk_fsm = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic frame_valid = 1'b0;
  logic eng_finish = 1'b0;
  logic vec_req = 1'b0;
  logic img_req = 1'b0;
  logic fifo_full = 1'b0;
  logic abort = 1'b0;
  logic err_clr = 1'b0;
  logic [MSBI:0] window_cfg = '0;
  logic [2*MSBI+3:0] vec_data = '0;
  logic [25:0] img_data = '0;

  logic frame_ack, eng_start, bank_sel;
  logic vec_wait, img_wait, fifo_wr, error;
  logic [MSBI:0] window_limit;
  logic [1:0] cont_img;
  logic [31:0] fifo_data;
  logic [15:0] frames_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  ack_t qa[$];
  st_t  qs[$];
  arb_t qarb[$];

  logic [1:0]  m_tag = '0;
  logic        m_bank = 1'b0;
  logic [15:0] m_done = '0;
  logic [13:0] m_win = '0;

  me_frame_sched #(
    .MSBI(MSBI),
    .TO_W(TO_W)
  ) dut (
    .clk_fsm     (clk_fsm),
    .rst_n       (rst_n),
    .enable      (enable),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .window_cfg  (window_cfg),
    .window_limit(window_limit),
    .eng_start   (eng_start),
    .eng_finish  (eng_finish),
    .cont_img    (cont_img),
    .bank_sel    (bank_sel),
    .vec_req     (vec_req),
    .img_req     (img_req),
    .vec_data    (vec_data),
    .img_data    (img_data),
    .vec_wait    (vec_wait),
    .img_wait    (img_wait),
    .fifo_full   (fifo_full),
    .fifo_wr     (fifo_wr),
    .fifo_data   (fifo_data),
    .abort       (abort),
    .err_clr     (err_clr),
    .error       (error),
    .frames_done (frames_done)
  );

  always #5 clk_fsm = ~clk_fsm;

  always @(posedge clk_fsm) cyc <= cyc + 1;

  always @(posedge clk_fsm) begin
    if (cyc > 20000) begin
      $display("FAIL cycle_budget: got %0d cycles, limit 20000", cyc);
      $fatal(1, "cycle budget exceeded");
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic oops(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got event, expected none", nm);
  endtask

  // ---------------- monitor ----------------
  arb_t ma;
  ack_t pk;
  st_t  ms;
  bit   pend = 1'b0;
  logic [19:0] prev = '0;
  logic [19:0] now_s;

  always @(negedge clk_fsm) begin
    if (mon_en) begin
      if (qarb.size() > 0) begin
        ma = qarb.pop_front();
        chk("arb", {fifo_wr, vec_wait, img_wait, fifo_data},
            {ma.wr, ma.vw, ma.iw, ma.data});
      end
      if (pend && cyc == pk.cyc + 1) begin
        chk("eng_start", eng_start, pk.start);
        chk("window_limit", window_limit, pk.win);
        pend = 1'b0;
      end else if (eng_start) begin
        oops("unexpected_start");
      end
      if (frame_ack) begin
        if (qa.size() == 0) begin
          oops("unexpected_ack");
        end else begin
          pk = qa.pop_front();
          chk("ack_cycle", cyc, pk.cyc);
          pend = 1'b1;
        end
      end
      now_s = {error, cont_img, bank_sel, frames_done};
      if (now_s != prev) begin
        if (qs.size() == 0) begin
          oops("unexpected_state_change");
        end else begin
          ms = qs.pop_front();
          chk("event_cycle", cyc, ms.cyc);
          chk("event_state", now_s,
              {ms.err, ms.tag, ms.bank, ms.done});
        end
        prev = now_s;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic vr, input logic ir,
                       input logic ff, output bit st);
    arb_t a;
    vec_req   = vr;
    img_req   = ir;
    fifo_full = ff;
    vec_data  = 30'($urandom);
    img_data  = 26'($urandom);
    a.vw = ff;
    a.iw = ff | vr;
    a.wr = (vr | ir) & ~ff;
    if (vr) a.data = {2'b01, vec_data};
    else if (ir) a.data = {2'b10, 4'b0000, img_data};
    else a.data = 32'h0;
    qarb.push_back(a);
    st = (vr | ir) & ff;
    @(posedge clk_fsm);
    #1;
    frame_valid = 1'b0;
    eng_finish  = 1'b0;
    abort       = 1'b0;
    err_clr     = 1'b0;
  endtask

  task automatic tick(input int pct, output bit st);
    logic vr, ir, ff;
    vr = 1'($urandom_range(0, 1));
    ir = 1'($urandom_range(0, 1));
    ff = ($urandom_range(0, 99) < pct);
    drive(vr, ir, ff, st);
  endtask

  // mode 0: finish, 1: finish+abort, 2: timeout, 3: abort
  task automatic run_frame(input logic [13:0] w, input int len,
                           input int mode, input int pct);
    bit s;
    int c, cnt, guard;
    ack_t k;
    enable      = 1'b1;
    window_cfg  = w;
    frame_valid = 1'b1;
    k.cyc   = cyc;
    k.win   = (w != 0) ? w : m_win;
    k.start = (w != 0);
    qa.push_back(k);
    tick(pct, s);
    if (w == 0) return;
    m_win = w;
    tick(pct, s);
    if (mode <= 1) begin
      for (int i = 0; i < len - 1; i++) tick(pct, s);
      c = cyc;
      eng_finish = 1'b1;
      abort = (mode == 1);
      m_tag  = m_tag + 2'd1;
      m_bank = ~m_bank;
      if (m_done != 16'hFFFF) m_done = m_done + 16'd1;
      qs.push_back('{c + 2, 1'b0, m_tag, m_bank, m_done});
      tick(pct, s);
      tick(pct, s);
    end else begin
      if (mode == 2) begin
        cnt = 0;
        guard = 0;
        c = cyc;
        while (cnt < 2**TO_W - 1 && guard < 400) begin
          c = cyc;
          tick(pct, s);
          if (!s) cnt++;
          guard++;
        end
        if (guard >= 400) oops("watchdog_guard");
        qs.push_back('{c + 1, 1'b1, m_tag, m_bank, m_done});
        frame_valid = 1'b1;
        tick(pct, s);
        frame_valid = 1'b1;
        tick(pct, s);
      end else begin
        for (int i = 0; i < len - 1; i++) tick(pct, s);
        c = cyc;
        abort = 1'b1;
        qs.push_back('{c + 1, 1'b1, m_tag, m_bank, m_done});
        tick(pct, s);
      end
      c = cyc;
      err_clr = 1'b1;
      qs.push_back('{c + 1, 1'b0, m_tag, m_bank, m_done});
      tick(pct, s);
    end
  endtask

  initial begin
    bit s;
    int n;
    rst_n = 1'b0;
    #2;
    chk("rst_ack", frame_ack, 0);
    chk("rst_start", eng_start, 0);
    chk("rst_error", error, 0);
    chk("rst_bank", bank_sel, 0);
    chk("rst_tag", cont_img, 0);
    chk("rst_win", window_limit, 0);
    chk("rst_done", frames_done, 0);
    vec_req  = 1'b1;
    vec_data = 30'h2ABCDEF1;
    #1;
    chk("rst_arb_wr", fifo_wr, 1);
    chk("rst_arb_data", fifo_data, {2'b01, 30'h2ABCDEF1});
    vec_req = 1'b0;
    @(posedge clk_fsm);
    @(posedge clk_fsm);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // enable low: held frame_valid is not acknowledged
    enable = 1'b0;
    window_cfg = 14'd400;
    repeat (3) begin
      frame_valid = 1'b1;
      tick(20, s);
    end

    // nominal frame plus tag/bank wrap over four frames
    run_frame(14'd400, 6, 0, 0);
    run_frame(14'd55, 3, 0, 30);
    run_frame(14'd1, 1, 0, 30);
    run_frame(14'h3FFF, 12, 0, 30);

    // arbiter priority and full handling
    drive(1'b1, 1'b1, 1'b0, s);
    drive(1'b1, 1'b1, 1'b1, s);
    drive(1'b0, 1'b1, 1'b0, s);
    drive(1'b0, 1'b1, 1'b1, s);
    drive(1'b0, 1'b0, 1'b1, s);

    // watchdog exact, then with stalls
    run_frame(14'd9, 1, 2, 0);
    run_frame(14'd10, 1, 2, 40);
    // finish beats abort; dropped frame; plain abort
    run_frame(14'd11, 4, 1, 10);
    run_frame(14'd0, 1, 0, 10);
    run_frame(14'd12, 5, 3, 10);

    for (int i = 0; i < 25; i++) begin
      logic [13:0] w;
      w = ($urandom_range(0, 9) == 0) ?
          14'd0 : 14'($urandom_range(1, 16383));
      run_frame(w, $urandom_range(1, 12),
                $urandom_range(0, 3), $urandom_range(0, 40));
      n = $urandom_range(0, 2);
      repeat (n) tick(20, s);
    end

    // async reset in the middle of a run
    enable = 1'b1;
    window_cfg = 14'd77;
    frame_valid = 1'b1;
    qa.push_back('{cyc, 14'd77, 1'b1});
    tick(10, s);
    tick(10, s);
    repeat (3) tick(10, s);
    m_tag = '0;
    m_bank = 1'b0;
    m_done = '0;
    m_win = '0;
    qs.push_back('{cyc, 1'b0, 2'd0, 1'b0, 16'd0});
    rst_n = 1'b0;
    #1;
    chk("arst_done", frames_done, 0);
    chk("arst_win", window_limit, 0);
    chk("arst_tag_bank", {cont_img, bank_sel}, 0);
    chk("arst_err_start", {error, eng_start}, 0);
    tick(10, s);
    tick(10, s);
    rst_n = 1'b1;
    run_frame(14'd123, 4, 0, 10);

    tick(0, s);
    tick(0, s);
    chk("ack_queue_left", qa.size(), 0);
    chk("event_queue_left", qs.size(), 0);
    chk("arb_queue_left", qarb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
